prio_arb_rr: RTL and testbench
==============================

// Module: prio_arb_rr
// PURPOSE
//  Parametrised successor to the 8:3 priority encoder. Registered N-way request
//  arbiter with enable and runtime mode select: fixed priority (highest index wins)
//  or round-robin. The winner is held as a valid/ack grant until the consumer
//  accepts it. Sits between request sources and a shared resource.
// PARAMETERS
//  N   8           number of requesters (N >= 2, need not be a power of 2)
//  W   $clog2(N)   width of the grant index (derived; do not override)
// PORTS
//  clk         in   1   rising-edge clock
//  rst_n       in   1   asynchronous active-low reset
//  en          in   1   arbitration enable; gates new grants only
//  mode        in   1   0 = fixed priority, 1 = round-robin
//  req         in   N   request vector; bit i = requester i
//  gnt_ack     in   1   consumer accepts the current grant; ignored unless gnt_valid=1
//  gnt_valid   out  1   a grant is held
//  gnt_idx     out  W   index of the granted requester
//  gnt_onehot  out  N   one-hot grant; equals (1<<gnt_idx) when valid, else 0
//  any_req     out  1   combinational OR-reduction of req, gated by en
// BEHAVIOUR
//  - Reset (async, rst_n=0): gnt_valid=0, gnt_idx=0, gnt_onehot=0, state=IDLE, last=0.
//    Reset mid-grant drops the grant immediately; no ack is required.
//  - FSM states: IDLE (no grant held) and GRANT (gnt_valid=1).
//    IDLE -> GRANT on an edge with en=1 and req!=0.
//    GRANT -> GRANT (new winner) on an edge with gnt_ack=1, en=1 and req!=0
//      (back-to-back, no bubble).
//    GRANT -> IDLE on an edge with gnt_ack=1 and (en=0 or req=0).
//    GRANT holds with gnt_idx unchanged while gnt_ack=0.
//  - Latency: req sampled at edge k gives gnt_valid=1 after edge k (1 cycle).
//  - Winner selection from the req value sampled at the arbitration edge:
//    fixed (mode=0): highest set index, as in the 8:3 encoder (bit N-1 highest).
//    round-robin (mode=1): search downward starting at (last-1) mod N, wrapping
//      N-1 after 0; the first set bit wins. last=0 after reset, so the first RR
//      search starts at N-1.
//  - last updates to gnt_idx on every accepted grant (gnt_valid & gnt_ack), in
//    both modes. Mode changes take effect at the next arbitration edge.
//  - Sticky grant: if the granted requester drops its req while waiting for ack,
//    the grant is still held.
//  - en=0 during GRANT does not cancel the grant. It only blocks the next one.
//  - gnt_ack while gnt_valid=0 has no effect.
//  - Exactly one gnt_onehot bit is set when gnt_valid=1. All bits are 0 otherwise.
//  - The gnt_idx value is don't-care while gnt_valid=0. It holds its last value.
//  - All outputs except any_req are registered.
// TESTING
//  1 Reset: assert rst_n=0 mid-grant -> gnt_valid=0, gnt_onehot=0 with no clock
//    edge. After release with req=0 -> stays IDLE.
//  2 Fixed mode, N=8, en=1, ack on every grant:
//    req=8'h01 -> idx 0.
//    req=8'h06 -> idx 2.
//    req=8'h18 -> idx 4.
//    req=8'h49 -> idx 6.
//    req=8'h81 repeated -> idx 7,7,7.
//  3 Round-robin, req=8'h81 held, ack on every grant -> idx 7,0,7,0.
//    req=8'hFF held -> idx 7,6,5,...,0,7.
//  4 Enable and hold:
//    en=0, req=8'h80 -> gnt_valid stays 0.
//    en=1 -> grant after 1 cycle. Drop req and keep ack=0 for 5 cycles ->
//      grant held with idx 7.
//    en=0 then ack -> IDLE.
//  5 Back-to-back: ack held high with req=8'h0C, mode=1 -> gnt_valid stays 1
//    and idx alternates 3,2,3 each cycle.
//  6 Mode switch: RR grants idx 5 from req=8'hA0. Switch to mode=0 and ack ->
//    next idx=7 (fixed priority ignores last).

Source files
------------

// File: rtl/prio_arb_rr.sv
// Registered N-way request arbiter, fixed-priority or round-robin, valid/ack grant hold.
// Latency 1 cycle from req to gnt_valid; a grant is held until acked, and ack with a live request re-arbitrates without a bubble.
module prio_arb_rr #(
   parameter int N = 8,
   parameter int W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         mode,
   input  logic [N-1:0] req,
   input  logic         gnt_ack,
   output logic         gnt_valid,
   output logic [W-1:0] gnt_idx,
   output logic [N-1:0] gnt_onehot,
   output logic         any_req
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t         state, state_nxt;
   logic [W-1:0]   last, last_nxt;
   logic [W-1:0]   idx_nxt;
   logic [N-1:0]   onehot_nxt;
   logic [W-1:0]   base;
   logic [W-1:0]   win;
   logic           found;
   logic           accept;
   logic           arb_ok;
   int             pos;

   assign any_req   = en & (|req);
   assign gnt_valid = (state == GRANT);
   assign accept    = gnt_valid & gnt_ack;
   assign arb_ok    = en & (|req);

   // An ack on this edge moves the round-robin pointer first, so a back-to-back
   // re-arbitration already searches below the grant being retired.
   assign base = accept ? gnt_idx : last;

   always_comb begin
      win   = '0;
      found = 1'b0;
      pos   = 0;
      if (!mode) begin
         for (int i = 0; i < N; i++) begin
            if (req[W'(i)]) win = W'(i);
         end
      end else begin
         for (int k = 1; k <= N; k++) begin
            pos = int'(base) - k;
            if (pos < 0) pos = pos + N;
            if (!found && req[W'(pos)]) begin
               win   = W'(pos);
               found = 1'b1;
            end
         end
      end
   end

   always_comb begin
      state_nxt  = state;
      idx_nxt    = gnt_idx;
      onehot_nxt = gnt_onehot;
      last_nxt   = last;
      if (accept) last_nxt = gnt_idx;
      case (state)
         IDLE: begin
            if (arb_ok) begin
               state_nxt  = GRANT;
               idx_nxt    = win;
               onehot_nxt = {{(N-1){1'b0}}, 1'b1} << win;
            end
         end
         GRANT: begin
            if (gnt_ack) begin
               if (arb_ok) begin
                  idx_nxt    = win;
                  onehot_nxt = {{(N-1){1'b0}}, 1'b1} << win;
               end else begin
                  state_nxt  = IDLE;
                  onehot_nxt = '0;
               end
            end
         end
         default: begin
            state_nxt  = IDLE;
            onehot_nxt = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         gnt_idx    <= '0;
         gnt_onehot <= '0;
         last       <= '0;
      end else begin
         state      <= state_nxt;
         gnt_idx    <= idx_nxt;
         gnt_onehot <= onehot_nxt;
         last       <= last_nxt;
      end
   end

endmodule

// File: tb/tb_prio_arb_rr.sv
// Bench for prio_arb_rr (N=8): directed scenarios plus random traffic against a
// transaction-level model of the arbitration rules.
module tb_prio_arb_rr;

   logic       clk;
   logic       rst_n;
   logic       en;
   logic       mode;
   logic [7:0] req;
   logic       gnt_ack;
   logic       gnt_valid;
   logic [2:0] gnt_idx;
   logic [7:0] gnt_onehot;
   logic       any_req;

   int n_checks;
   int n_fail;

   bit m_valid;
   int m_idx;
   int m_last;

   prio_arb_rr #(.N(8)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .mode       (mode),
      .req        (req),
      .gnt_ack    (gnt_ack),
      .gnt_valid  (gnt_valid),
      .gnt_idx    (gnt_idx),
      .gnt_onehot (gnt_onehot),
      .any_req    (any_req)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int pick(input logic [7:0] r, input logic m, input int lst);
      int i;
      if (!m) begin
         for (int j = 7; j >= 0; j--) if (r[j]) return j;
      end else begin
         for (int k = 1; k <= 8; k++) begin
            i = (lst - k + 8) % 8;
            if (r[i]) return i;
         end
      end
      return 0;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      logic [7:0] e1;
      e1 = m_valid ? (8'd1 << m_idx) : 8'd0;
      chk({tag, ".valid"}, 32'(gnt_valid), 32'(m_valid));
      chk({tag, ".onehot"}, 32'(gnt_onehot), 32'(e1));
      if (m_valid) chk({tag, ".idx"}, 32'(gnt_idx), 32'(m_idx));
      chk({tag, ".any_req"}, 32'(any_req), 32'(en && (req != 8'd0)));
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_idx   = 0;
      m_last  = 0;
   endtask

   // Advance one clock edge in both model and DUT, then compare.
   task automatic tick(input string tag);
      bit acc;
      acc = m_valid && gnt_ack;
      if (acc) m_last = m_idx;
      if (en && req != 8'd0 && (!m_valid || gnt_ack)) begin
         m_idx   = pick(req, mode, m_last);
         m_valid = 1'b1;
      end else if (acc) begin
         m_valid = 1'b0;
      end
      @(posedge clk);
      #1;
      check_all(tag);
   endtask

   task automatic tick_idx(input string tag, input int exp_idx);
      tick(tag);
      chk({tag, ".const"}, 32'(gnt_idx), 32'(exp_idx));
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      model_reset();
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      logic [7:0] fx_req [7];
      int         fx_exp [7];
      logic [7:0] r;

      n_checks = 0;
      n_fail   = 0;
      rst_n    = 1'b0;
      en       = 1'b0;
      mode     = 1'b0;
      req      = 8'd0;
      gnt_ack  = 1'b0;
      model_reset();

      #12;
      check_all("reset");
      rst_n = 1'b1;
      tick("post_reset_idle");

      // Fixed priority, ack on every grant.
      fx_req = '{8'h01, 8'h06, 8'h18, 8'h49, 8'h81, 8'h81, 8'h81};
      fx_exp = '{0, 2, 4, 6, 7, 7, 7};
      en = 1'b1; gnt_ack = 1'b1;
      for (int i = 0; i < 7; i++) begin
         req = fx_req[i];
         tick_idx("fixed", fx_exp[i]);
      end
      req = 8'h00;
      tick("fixed_drain");
      tick("ack_while_idle");

      // Round-robin from a freshly reset pointer.
      do_reset();
      mode = 1'b1; req = 8'h81;
      tick_idx("rr81", 7);
      tick_idx("rr81", 0);
      tick_idx("rr81", 7);
      tick_idx("rr81", 0);
      req = 8'hFF;
      for (int i = 7; i >= 0; i--) tick_idx("rrFF", i);
      tick_idx("rrFF_wrap", 7);
      req = 8'h00;
      tick("rr_drain");

      // Enable gating and sticky hold.
      mode = 1'b0; en = 1'b0; gnt_ack = 1'b0; req = 8'h80;
      tick("en_off");
      tick("en_off");
      en = 1'b1;
      tick_idx("en_on", 7);
      req = 8'h00;
      for (int i = 0; i < 5; i++) tick_idx("sticky", 7);
      en = 1'b0; gnt_ack = 1'b1;
      tick("en_off_ack");
      gnt_ack = 1'b0;

      // Back-to-back round-robin with ack held.
      en = 1'b1; mode = 1'b1; req = 8'h0C; gnt_ack = 1'b1;
      tick_idx("b2b", 3);
      tick_idx("b2b", 2);
      tick_idx("b2b", 3);
      req = 8'h00;
      tick("b2b_drain");

      // Mode switch ignores the round-robin pointer.
      do_reset();
      mode = 1'b1; req = 8'hA0; gnt_ack = 1'b1;
      tick_idx("rrA0", 7);
      tick_idx("rrA0", 5);
      gnt_ack = 1'b0;
      tick_idx("rrA0_hold", 5);
      mode = 1'b0; gnt_ack = 1'b1;
      tick_idx("mode_switch", 7);

      // Asynchronous reset mid-grant, checked between clock edges.
      gnt_ack = 1'b0;
      #2;
      rst_n = 1'b0;
      model_reset();
      #1;
      chk("async_rst.valid", 32'(gnt_valid), 32'd0);
      chk("async_rst.onehot", 32'(gnt_onehot), 32'd0);
      #1;
      rst_n = 1'b1;
      req = 8'h00;
      tick("rst_release");
      tick("rst_release");

      // Random traffic against the model.
      for (int c = 0; c < 400; c++) begin
         en = ($urandom_range(0, 9) != 0);
         if ($urandom_range(0, 15) == 0) mode = ~mode;
         r = 8'($urandom);
         if ($urandom_range(0, 3) == 0) r = 8'h00;
         else if ($urandom_range(0, 1) == 0) r = r & 8'($urandom);
         req = r;
         gnt_ack = ($urandom_range(0, 2) != 0);
         tick("rand");
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
